// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and framebuffer reader.
// Counter -> address/flags -> RAM -> registered pins, latency 3.
module vga_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter logic [23:0] BORDER   = 24'h202020
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] RADDR,
  input  logic [23:0] RDATA,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VBLANK_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS0     = H_ACTIVE + H_FP;
  localparam int HS1     = HS0 + H_SYNC;
  localparam int VS0     = V_ACTIVE + V_FP;
  localparam int VS1     = VS0 + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge CLK) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  logic [31:0] hx;
  logic [31:0] vx;
  logic        c_act;
  logic        c_win;
  logic        c_hs;
  logic        c_vs;
  logic        c_vbs;
  logic [15:0] c_addr;

  // Window bounds are tested on raw h/v so nothing left of or
  // above the image aliases into it through the 8-bit offsets.
  always_comb begin
    hx     = 32'(h);
    vx     = 32'(v);
    c_act  = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    c_win  = c_act
          && (hx >= IMG_X0) && (hx < IMG_X0 + 256)
          && (vx >= IMG_Y0) && (vx < IMG_Y0 + 256);
    c_addr = 16'h0000;
    if (c_win)
      c_addr = {8'(vx - 32'(IMG_Y0)), 8'(hx - 32'(IMG_X0))};
    c_hs   = !((hx >= HS0) && (hx < HS1));
    c_vs   = !((vx >= VS0) && (vx < VS1));
    c_vbs  = (hx == 0) && (vx == V_ACTIVE);
  end

  logic s1_vld, s1_act, s1_win, s1_hs, s1_vs, s1_vbs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      s1_act <= 1'b0;
      s1_win <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_vbs <= 1'b0;
      RADDR  <= 16'h0000;
    end else begin
      s1_vld <= 1'b1;
      s1_act <= c_act;
      s1_win <= c_win;
      s1_hs  <= c_hs;
      s1_vs  <= c_vs;
      s1_vbs <= c_vbs;
      RADDR  <= c_addr;
    end
  end

  logic s2_vld, s2_act, s2_win, s2_hs, s2_vs, s2_vbs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_vld <= 1'b0;
      s2_act <= 1'b0;
      s2_win <= 1'b0;
      s2_hs  <= 1'b1;
      s2_vs  <= 1'b1;
      s2_vbs <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      s2_act <= s1_act;
      s2_win <= s1_win;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_vbs <= s1_vbs;
    end
  end

  logic [23:0] pix;

  always_comb begin
    pix = 24'h000000;
    unique case (1'b1)
      s2_win:             pix = RDATA;
      (s2_act && !s2_win): pix = BORDER;
      default:            pix = 24'h000000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || !s2_vld) begin
      {VGA_R, VGA_G, VGA_B} <= 24'h000000;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      VBLANK_START <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= pix;
      VGA_HS       <= s2_hs;
      VGA_VS       <= s2_vs;
      VGA_BLANK_N  <= s2_act;
      VBLANK_START <= s2_vbs;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random framebuffer, three parameter sets,
// per-cycle comparison against a time-to-position model.
module tb_vga_scanout;

  typedef struct {
    int          ha, hf, hs, hb;
    int          va, vf, vs, vb;
    int          x0, y0;
    logic [23:0] bd;
  } cfg_t;

  logic        CLK;
  logic        RST;
  logic [23:0] fb [65536];

  int checks;
  int failures;
  int cur_t;
  int n_vbs_sm;
  int n_vbs_big;

  cfg_t c_big, c_w0, c_sm;

  logic [15:0] ra_big, ra_w0, ra_sm;
  logic [23:0] rd_big, rd_w0, rd_sm;
  logic [7:0]  r_big, g_big, b_big;
  logic [7:0]  r_w0, g_w0, b_w0;
  logic [7:0]  r_sm, g_sm, b_sm;
  logic        hs_big, vs_big, bn_big, vbs_big;
  logic        hs_w0, vs_w0, bn_w0, vbs_w0;
  logic        hs_sm, vs_sm, bn_sm, vbs_sm;

  always @(posedge CLK) begin
    rd_big <= fb[ra_big];
    rd_w0  <= fb[ra_w0];
    rd_sm  <= fb[ra_sm];
  end

  vga_scanout u_big (
    .CLK(CLK), .RST(RST),
    .RADDR(ra_big), .RDATA(rd_big),
    .VGA_R(r_big), .VGA_G(g_big), .VGA_B(b_big),
    .VGA_HS(hs_big), .VGA_VS(vs_big),
    .VGA_BLANK_N(bn_big), .VBLANK_START(vbs_big)
  );

  vga_scanout #(
    .IMG_X0(0), .IMG_Y0(0), .BORDER(24'hFF0000)
  ) u_w0 (
    .CLK(CLK), .RST(RST),
    .RADDR(ra_w0), .RDATA(rd_w0),
    .VGA_R(r_w0), .VGA_G(g_w0), .VGA_B(b_w0),
    .VGA_HS(hs_w0), .VGA_VS(vs_w0),
    .VGA_BLANK_N(bn_w0), .VBLANK_START(vbs_w0)
  );

  vga_scanout #(
    .H_ACTIVE(260), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(258), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_X0(2), .IMG_Y0(1), .BORDER(24'h3C5A96)
  ) u_sm (
    .CLK(CLK), .RST(RST),
    .RADDR(ra_sm), .RDATA(rd_sm),
    .VGA_R(r_sm), .VGA_G(g_sm), .VGA_B(b_sm),
    .VGA_HS(hs_sm), .VGA_VS(vs_sm),
    .VGA_BLANK_N(bn_sm), .VBLANK_START(vbs_sm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h",
               tag, cur_t, got, exp);
    end
  endtask

  // Position presented by the pins at time t, or -1 during reset latency.
  function automatic int pos_of(cfg_t c, int t, int lat);
    int ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (t < lat) return -1;
    return (t - lat) % (ht * vt);
  endfunction

  function automatic logic [27:0] m_out(cfg_t c, int t);
    int p, ht, h, v;
    logic act, win, hs, vs;
    logic [23:0] col;
    p = pos_of(c, t, 3);
    if (p < 0) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht  = c.ha + c.hf + c.hs + c.hb;
    h   = p % ht;
    v   = p / ht;
    act = (h < c.ha) && (v < c.va);
    win = act && h >= c.x0 && h < c.x0 + 256
              && v >= c.y0 && v < c.y0 + 256;
    if (win)      col = fb[(v - c.y0) * 256 + (h - c.x0)];
    else if (act) col = c.bd;
    else          col = 24'h0;
    hs = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hs);
    vs = !(v >= c.va + c.vf && v < c.va + c.vf + c.vs);
    return {col, hs, vs, act, (h == 0 && v == c.va)};
  endfunction

  function automatic logic [15:0] m_addr(cfg_t c, int t);
    int p, ht, h, v;
    p = pos_of(c, t, 1);
    if (p < 0) return 16'h0;
    ht = c.ha + c.hf + c.hs + c.hb;
    h  = p % ht;
    v  = p / ht;
    if (h < c.ha && v < c.va
        && h >= c.x0 && h < c.x0 + 256
        && v >= c.y0 && v < c.y0 + 256)
      return 16'((v - c.y0) * 256 + (h - c.x0));
    return 16'h0;
  endfunction

  task automatic step_checks();
    chk("big_out",
        {4'h0, r_big, g_big, b_big, hs_big, vs_big, bn_big, vbs_big},
        {4'h0, m_out(c_big, cur_t)});
    chk("big_raddr", {16'h0, ra_big}, {16'h0, m_addr(c_big, cur_t)});
    chk("w0_out",
        {4'h0, r_w0, g_w0, b_w0, hs_w0, vs_w0, bn_w0, vbs_w0},
        {4'h0, m_out(c_w0, cur_t)});
    chk("w0_raddr", {16'h0, ra_w0}, {16'h0, m_addr(c_w0, cur_t)});
    chk("sm_out",
        {4'h0, r_sm, g_sm, b_sm, hs_sm, vs_sm, bn_sm, vbs_sm},
        {4'h0, m_out(c_sm, cur_t)});
    chk("sm_raddr", {16'h0, ra_sm}, {16'h0, m_addr(c_sm, cur_t)});
    if (cur_t == 3 + 256)
      chk("w0_pix_256_0", {8'h0, r_w0, g_w0, b_w0}, 32'h00FF0000);
    if (vbs_sm)  n_vbs_sm++;
    if (vbs_big) n_vbs_big++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step_checks();
      @(negedge CLK);
      cur_t++;
    end
  endtask

  initial begin
    int n1;
    checks    = 0;
    failures  = 0;
    cur_t     = 0;
    n_vbs_sm  = 0;
    n_vbs_big = 0;
    c_big = '{640, 16, 96, 48, 480, 10, 2, 33, 192, 112, 24'h202020};
    c_w0  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 24'hFF0000};
    c_sm  = '{260, 1, 2, 1, 258, 1, 2, 1, 2, 1, 24'h3C5A96};
    for (int i = 0; i < 65536; i++) fb[i] = 24'($urandom);
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST   = 1'b0;
    cur_t = 0;
    // One full small frame, then stop with the small counter at h=263
    // so sync-region flags are in flight when reset hits.
    n1 = 69168 + 264 * $urandom_range(1, 6) + 263;
    run(n1);
    chk("sm_vbs_count", n_vbs_sm, 1);
    chk("big_vbs_count", n_vbs_big, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    cur_t = 0;
    run(1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
